// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit: the per-cycle action and its priority encoder.
package pc_pkg;

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_INC,
    ACT_LD,
    ACT_CALL,
    ACT_RET,
    ACT_INTR
  } pc_act_e;

  // Exactly one action per cycle; lower-priority strobes are simply dropped.
  function automatic pc_act_e pick_act(input logic intr, input logic ret, input logic call,
                                       input logic ld, input logic inc);
    if (intr)      return ACT_INTR;
    else if (ret)  return ACT_RET;
    else if (call) return ACT_CALL;
    else if (ld)   return ACT_LD;
    else if (inc)  return ACT_INC;
    else           return ACT_HOLD;
  endfunction

endpackage

// File: rtl/pc_stack_unit_if.sv
// Command strobes from the control unit and PC/stack status back to it.
interface pc_stack_unit_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] DIN;
  logic              PC_LD;
  logic              PC_INC;
  logic              CALL;
  logic              RET;
  logic              INTR;
  logic [ADDR_W-1:0] PC_COUNT;
  logic              STK_EMPTY;
  logic              STK_FULL;
  logic              STK_ERR;

  modport master (
    output DIN, PC_LD, PC_INC, CALL, RET, INTR,
    input  PC_COUNT, STK_EMPTY, STK_FULL, STK_ERR
  );

  modport slave (
    input  DIN, PC_LD, PC_INC, CALL, RET, INTR,
    output PC_COUNT, STK_EMPTY, STK_FULL, STK_ERR
  );
endinterface

// File: rtl/pc_stack_unit_return_stack.sv
// Register-array LIFO for return addresses; a push is poppable on the very next cycle.
// Overflowing pushes and underflowing pops are dropped and reported as one-cycle pulses.
module return_stack #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] top_idx;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign ovf     = push & full;
  assign unf     = pop & empty;
  assign top_idx = count_q - 1'b1;
  // Only meaningful when not empty; the caller guards on empty.
  assign top     = mem_q[top_idx[PTR_W-1:0]];

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (push && !full) begin
      mem_d[count_q[PTR_W-1:0]] = din;
      count_d                   = count_q + 1'b1;
    end else if (pop && !empty) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) count_q <= '0;
    else     count_q <= count_d;
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Fetch-stage program counter with increment, load, call/return and interrupt vectoring.
// Return addresses are kept in an internal LIFO; STK_ERR latches any overflow or underflow.
module pc_stack_unit
  import pc_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int STACK_DEPTH = 8,
  parameter int RST_VEC     = 0,
  parameter int INTR_VEC    = 'h3FF
) (
  input logic            CLK,
  input logic            RST,
  pc_stack_unit_if.slave bus
);
  localparam logic [ADDR_W-1:0] RST_V  = ADDR_W'(RST_VEC);
  localparam logic [ADDR_W-1:0] INTR_V = ADDR_W'(INTR_VEC);

  pc_act_e           act;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, push_dat, stk_top;
  logic              err_q, err_d;
  logic              push, pop, empty, full, ovf, unf;

  assign act      = pick_act(bus.INTR, bus.RET, bus.CALL, bus.PC_LD, bus.PC_INC);
  assign pc_inc   = pc_q + 1'b1;
  assign push     = (act == ACT_CALL) || (act == ACT_INTR);
  assign pop      = (act == ACT_RET);
  // CALL returns past itself; INTR resumes the interrupted instruction.
  assign push_dat = (act == ACT_CALL) ? pc_inc : pc_q;

  return_stack #(
    .WIDTH(ADDR_W),
    .DEPTH(STACK_DEPTH)
  ) u_stack (
    .CLK  (CLK),
    .RST  (RST),
    .push (push),
    .pop  (pop),
    .din  (push_dat),
    .top  (stk_top),
    .empty(empty),
    .full (full),
    .ovf  (ovf),
    .unf  (unf)
  );

  always_comb begin
    pc_d = pc_q;
    unique case (act)
      ACT_INC:          pc_d = pc_inc;
      ACT_LD, ACT_CALL: pc_d = bus.DIN;
      ACT_INTR:         pc_d = INTR_V;
      ACT_RET:          if (!empty) pc_d = stk_top;
      default:          pc_d = pc_q;
    endcase
    err_d = err_q | ovf | unf;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q  <= RST_V;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign bus.PC_COUNT  = pc_q;
  assign bus.STK_EMPTY = empty;
  assign bus.STK_FULL  = full;
  assign bus.STK_ERR   = err_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit: expected PC/flags are queued as each command is driven.
module tb_pc_stack_unit;
  localparam int AW    = 10;
  localparam int DEPTH = 8;

  // Command bit order: {rst, intr, ret, call, ld, inc}
  localparam logic [5:0] C_HOLD = 6'b000000;
  localparam logic [5:0] C_INC  = 6'b000001;
  localparam logic [5:0] C_LD   = 6'b000010;
  localparam logic [5:0] C_CALL = 6'b000100;
  localparam logic [5:0] C_RET  = 6'b001000;
  localparam logic [5:0] C_INTR = 6'b010000;
  localparam logic [5:0] C_RST  = 6'b100000;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic          empty;
    logic          full;
    logic          err;
  } exp_t;

  typedef struct {
    logic [5:0]    cmd;
    logic [AW-1:0] din;
    exp_t          exp;
  } vec_t;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 CLK = ~CLK;

  pc_stack_unit_if #(.ADDR_W(AW)) bus ();

  pc_stack_unit #(
    .ADDR_W     (AW),
    .STACK_DEPTH(DEPTH),
    .RST_VEC    (0),
    .INTR_VEC   ('h3FF)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  function automatic vec_t mk(input logic [5:0] c, input logic [AW-1:0] d, input logic [AW-1:0] pc,
                              input logic em, input logic fu, input logic er);
    vec_t v;
    v.cmd = c;
    v.din = d;
    v.exp = '{pc: pc, empty: em, full: fu, err: er};
    return v;
  endfunction

  // Apply one command for one clock, then leave outputs settled for sampling.
  task automatic drive(input logic [5:0] c, input logic [AW-1:0] d);
    {RST, bus.INTR, bus.RET, bus.CALL, bus.PC_LD, bus.PC_INC} = c;
    bus.DIN = d;
    @(posedge CLK);
    #1;
    {RST, bus.INTR, bus.RET, bus.CALL, bus.PC_LD, bus.PC_INC} = C_HOLD;
  endtask

  task automatic test_reset();
    vec_t v[$];
    exp_t e, obs;
    v.push_back(mk(C_RST, 10'h000, 10'h000, 1, 0, 0));
    v.push_back(mk(C_INC, 10'h000, 10'h001, 1, 0, 0));
    v.push_back(mk(C_INC, 10'h000, 10'h002, 1, 0, 0));
    v.push_back(mk(C_INC, 10'h000, 10'h003, 1, 0, 0));
    foreach (v[i]) begin
      exp_q.push_back(v[i].exp);
      drive(v[i].cmd, v[i].din);
      e   = exp_q.pop_front();
      obs = {bus.PC_COUNT, bus.STK_EMPTY, bus.STK_FULL, bus.STK_ERR};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset[%0d]: got pc=%h e/f/err=%b%b%b, want pc=%h e/f/err=%b%b%b",
                 i, obs.pc, obs.empty, obs.full, obs.err, e.pc, e.empty, e.full, e.err);
      end
    end
  endtask

  task automatic test_wrap_priority();
    vec_t v[$];
    exp_t e, obs;
    v.push_back(mk(C_LD,        10'h3FE, 10'h3FE, 1, 0, 0));
    v.push_back(mk(C_INC,       10'h000, 10'h3FF, 1, 0, 0));
    v.push_back(mk(C_INC,       10'h000, 10'h000, 1, 0, 0));
    v.push_back(mk(C_LD | C_INC, 10'h055, 10'h055, 1, 0, 0));
    v.push_back(mk(C_HOLD,      10'h123, 10'h055, 1, 0, 0));
    foreach (v[i]) begin
      exp_q.push_back(v[i].exp);
      drive(v[i].cmd, v[i].din);
      e   = exp_q.pop_front();
      obs = {bus.PC_COUNT, bus.STK_EMPTY, bus.STK_FULL, bus.STK_ERR};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL wrap_prio[%0d]: got pc=%h e/f/err=%b%b%b, want pc=%h e/f/err=%b%b%b",
                 i, obs.pc, obs.empty, obs.full, obs.err, e.pc, e.empty, e.full, e.err);
      end
    end
  endtask

  task automatic test_call_ret();
    vec_t v[$];
    exp_t e, obs;
    v.push_back(mk(C_LD,   10'h010, 10'h010, 1, 0, 0));
    v.push_back(mk(C_CALL, 10'h100, 10'h100, 0, 0, 0));
    v.push_back(mk(C_CALL, 10'h200, 10'h200, 0, 0, 0));
    v.push_back(mk(C_RET,  10'h000, 10'h101, 0, 0, 0));
    v.push_back(mk(C_RET,  10'h000, 10'h011, 1, 0, 0));
    foreach (v[i]) begin
      exp_q.push_back(v[i].exp);
      drive(v[i].cmd, v[i].din);
      e   = exp_q.pop_front();
      obs = {bus.PC_COUNT, bus.STK_EMPTY, bus.STK_FULL, bus.STK_ERR};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL call_ret[%0d]: got pc=%h e/f/err=%b%b%b, want pc=%h e/f/err=%b%b%b",
                 i, obs.pc, obs.empty, obs.full, obs.err, e.pc, e.empty, e.full, e.err);
      end
    end
  endtask

  // Interrupt priority over CALL, then back-to-back CALL/RET with no idle cycle.
  task automatic test_intr_back_to_back();
    vec_t v[$];
    exp_t e, obs;
    v.push_back(mk(C_LD,           10'h020, 10'h020, 1, 0, 0));
    v.push_back(mk(C_INTR | C_CALL, 10'h100, 10'h3FF, 0, 0, 0));
    v.push_back(mk(C_RET,          10'h000, 10'h020, 1, 0, 0));
    v.push_back(mk(C_CALL,         10'h050, 10'h050, 0, 0, 0));
    v.push_back(mk(C_RET,          10'h000, 10'h021, 1, 0, 0));
    v.push_back(mk(C_CALL,         10'h060, 10'h060, 0, 0, 0));
    v.push_back(mk(C_RET | C_CALL, 10'h070, 10'h022, 1, 0, 0));
    foreach (v[i]) begin
      exp_q.push_back(v[i].exp);
      drive(v[i].cmd, v[i].din);
      e   = exp_q.pop_front();
      obs = {bus.PC_COUNT, bus.STK_EMPTY, bus.STK_FULL, bus.STK_ERR};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL intr_b2b[%0d]: got pc=%h e/f/err=%b%b%b, want pc=%h e/f/err=%b%b%b",
                 i, obs.pc, obs.empty, obs.full, obs.err, e.pc, e.empty, e.full, e.err);
      end
    end
  endtask

  task automatic test_ovf_unf();
    vec_t v[$];
    exp_t e, obs;
    for (int k = 0; k <= DEPTH; k++)
      v.push_back(mk(C_CALL, AW'(10'h100 + k), AW'(10'h100 + k), 0, (k >= DEPTH - 1), (k == DEPTH)));
    // The dropped 9th push must not have clobbered the 8th entry (0x106 + 1).
    v.push_back(mk(C_RET, 10'h000, 10'h107, 0, 0, 1));
    v.push_back(mk(C_RST, 10'h000, 10'h000, 1, 0, 0));
    v.push_back(mk(C_RET, 10'h000, 10'h000, 1, 0, 1));
    v.push_back(mk(C_INC, 10'h000, 10'h001, 1, 0, 1));
    v.push_back(mk(C_RST, 10'h000, 10'h000, 1, 0, 0));
    foreach (v[i]) begin
      exp_q.push_back(v[i].exp);
      drive(v[i].cmd, v[i].din);
      e   = exp_q.pop_front();
      obs = {bus.PC_COUNT, bus.STK_EMPTY, bus.STK_FULL, bus.STK_ERR};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL ovf_unf[%0d]: got pc=%h e/f/err=%b%b%b, want pc=%h e/f/err=%b%b%b",
                 i, obs.pc, obs.empty, obs.full, obs.err, e.pc, e.empty, e.full, e.err);
      end
    end
  endtask

  task automatic test_rst_mid();
    vec_t v[$];
    exp_t e, obs;
    v.push_back(mk(C_CALL,        10'h100, 10'h100, 0, 0, 0));
    v.push_back(mk(C_CALL,        10'h200, 10'h200, 0, 0, 0));
    v.push_back(mk(C_CALL,        10'h300, 10'h300, 0, 0, 0));
    v.push_back(mk(C_RST | C_RET, 10'h000, 10'h000, 1, 0, 0));
    v.push_back(mk(C_RET,         10'h000, 10'h000, 1, 0, 1));
    v.push_back(mk(C_RST,         10'h000, 10'h000, 1, 0, 0));
    foreach (v[i]) begin
      exp_q.push_back(v[i].exp);
      drive(v[i].cmd, v[i].din);
      e   = exp_q.pop_front();
      obs = {bus.PC_COUNT, bus.STK_EMPTY, bus.STK_FULL, bus.STK_ERR};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL rst_mid[%0d]: got pc=%h e/f/err=%b%b%b, want pc=%h e/f/err=%b%b%b",
                 i, obs.pc, obs.empty, obs.full, obs.err, e.pc, e.empty, e.full, e.err);
      end
    end
  endtask

  initial begin
    RST        = 1'b1;
    bus.DIN    = '0;
    bus.PC_LD  = 1'b0;
    bus.PC_INC = 1'b0;
    bus.CALL   = 1'b0;
    bus.RET    = 1'b0;
    bus.INTR   = 1'b0;
    #2;
    test_reset();
    test_wrap_priority();
    test_call_ret();
    test_intr_back_to_back();
    test_ovf_unf();
    test_rst_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
